vec_mac_host_sequencer: RTL

//  Host-side initiator for the 8-lane compute-in-SRAM MAC pin protocol.

---
 rtl/vec_mac_pkg.sv | 23 ++
 rtl/vec_mac_host_sequencer_if.sv | 24 ++
 rtl/vec_mac_byte_deser.sv | 12 +
 rtl/vec_mac_host_sequencer.sv | 103 ++++++++++
 4 files changed

// File: rtl/vec_mac_pkg.sv
// vec_mac_pkg: shared constants, pin opcodes and FSM states for the MAC host sequencer
package vec_mac_pkg;
    localparam int N_MAC  = 8;
    localparam int DW     = 8;
    localparam int LW     = $clog2(N_MAC);
    localparam int SUM_W  = 2 * DW + LW;
    localparam int RD_LAT = 2;
    localparam int CAP_W  = 3 * 8;
    localparam logic [1:0] OP_LOAD_W = 2'b00;
    localparam logic [1:0] OP_LOAD_A = 2'b01;
    localparam logic [1:0] OP_READ_S = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;
    localparam logic [7:0] UI_NOP    = {OP_NOP, 6'd0};
    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_W,
        S_LD_A,
        S_RD,
        S_WAIT,
        S_CAP,
        S_DONE
    } state_t;
endpackage

// File: rtl/vec_mac_host_sequencer_if.sv
// vec_mac_host_sequencer_if: command, result and device-pin bundle between host logic and the sequencer
interface vec_mac_host_sequencer_if;
    import vec_mac_pkg::*;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_keep_w;
    logic [N_MAC*DW-1:0] cmd_w;
    logic [N_MAC*DW-1:0] cmd_a;
    logic                res_valid;
    logic                res_ready;
    logic [SUM_W-1:0]    res_data;
    logic                res_err;
    logic [7:0]          dev_ui;
    logic [7:0]          dev_uio;
    logic [7:0]          dev_uo;
    modport master (
        input  cmd_valid, cmd_keep_w, cmd_w, cmd_a, res_ready, dev_uo,
        output cmd_ready, res_valid, res_data, res_err, dev_ui, dev_uio
    );
    modport slave (
        output cmd_valid, cmd_keep_w, cmd_w, cmd_a, res_ready, dev_uo,
        input  cmd_ready, res_valid, res_data, res_err, dev_ui, dev_uio
    );
endinterface

// File: rtl/vec_mac_byte_deser.sv
// vec_mac_byte_deser: splits the MSB-first {hi, mid, lo} capture into the result and the overflow flag
module vec_mac_byte_deser
    import vec_mac_pkg::*;
(
    input  logic [CAP_W-1:0] i_cap,
    output logic [SUM_W-1:0] o_data,
    output logic             o_err
);
    assign o_data = i_cap[SUM_W-1:0];
    // any bit of hi above the legal sum width means the device broke protocol
    assign o_err  = |i_cap[CAP_W-1:SUM_W];
endmodule

// File: rtl/vec_mac_host_sequencer.sv
// vec_mac_host_sequencer: drives weight/activation loads and a READ_S onto the device pins, then captures the 3-byte sum
module vec_mac_host_sequencer
    import vec_mac_pkg::*;
(
    input logic                      i_clk,
    input logic                      i_rst_n,
    vec_mac_host_sequencer_if.master bus
);
    state_t              r_state, w_state_nx;
    logic [LW-1:0]       r_lane, w_lane_nx;
    logic [1:0]          r_byte, w_byte_nx;
    logic [N_MAC*DW-1:0] r_w, r_a, w_w_nx, w_a_nx;
    logic [7:0]          r_ui, r_uio, w_ui_nx, w_uio_nx;
    logic [CAP_W-1:0]    r_cap, w_cap_nx;
    logic                w_acc;
    logic                w_last;

    assign bus.cmd_ready = (r_state == S_IDLE) & i_rst_n;
    assign bus.res_valid = r_state == S_DONE;
    assign bus.dev_ui    = r_ui;
    assign bus.dev_uio   = r_uio;
    assign w_acc         = bus.cmd_valid & bus.cmd_ready;
    assign w_last        = r_lane == LW'(N_MAC - 1);

    always_comb begin
        w_state_nx = r_state;
        w_lane_nx  = r_lane;
        w_byte_nx  = r_byte;
        w_cap_nx   = r_cap;
        w_w_nx     = w_acc ? bus.cmd_w : r_w;
        w_a_nx     = w_acc ? bus.cmd_a : r_a;
        case (r_state)
            S_IDLE: begin
                w_state_nx = w_acc ? (bus.cmd_keep_w ? S_LD_A : S_LD_W) : S_IDLE;
                w_lane_nx  = '0;
            end
            S_LD_W: begin
                w_lane_nx  = w_last ? '0 : r_lane + LW'(1);
                w_state_nx = w_last ? S_LD_A : S_LD_W;
            end
            S_LD_A: begin
                w_lane_nx  = w_last ? '0 : r_lane + LW'(1);
                w_state_nx = w_last ? S_RD : S_LD_A;
            end
            S_RD: begin
                w_state_nx = (RD_LAT > 1) ? S_WAIT : S_CAP;
                w_lane_nx  = '0;
                w_byte_nx  = '0;
            end
            S_WAIT: begin
                w_lane_nx  = r_lane + LW'(1);
                w_state_nx = (r_lane == LW'(RD_LAT - 2)) ? S_CAP : S_WAIT;
            end
            S_CAP: begin
                w_cap_nx   = {r_cap[CAP_W-9:0], bus.dev_uo};
                w_byte_nx  = r_byte + 2'd1;
                w_state_nx = (r_byte == 2'd2) ? S_DONE : S_CAP;
            end
            S_DONE:  w_state_nx = bus.res_ready ? S_IDLE : S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
        // pins follow the state being entered, so the device sees them one edge later
        w_ui_nx  = UI_NOP;
        w_uio_nx = '0;
        if (w_state_nx == S_LD_W) begin
            w_ui_nx  = {OP_LOAD_W, 6'(w_lane_nx)};
            w_uio_nx = w_w_nx[w_lane_nx*DW +: DW];
        end else if (w_state_nx == S_LD_A) begin
            w_ui_nx  = {OP_LOAD_A, 6'(w_lane_nx)};
            w_uio_nx = w_a_nx[w_lane_nx*DW +: DW];
        end else if (w_state_nx == S_RD) begin
            w_ui_nx  = {OP_READ_S, 6'd0};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_lane  <= '0;
            r_byte  <= '0;
            r_w     <= '0;
            r_a     <= '0;
            r_ui    <= UI_NOP;
            r_uio   <= '0;
            r_cap   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_lane  <= w_lane_nx;
            r_byte  <= w_byte_nx;
            r_w     <= w_w_nx;
            r_a     <= w_a_nx;
            r_ui    <= w_ui_nx;
            r_uio   <= w_uio_nx;
            r_cap   <= w_cap_nx;
        end
    end

    vec_mac_byte_deser u_deser (
        .i_cap  (r_cap),
        .o_data (bus.res_data),
        .o_err  (bus.res_err)
    );
endmodule
